capture_sequencer: RTL and testbench

Controller for the input-capture datapath. It clears and arms the capture unit, and counts capture-done events. It accumulates 2^k period/high/low samples and averages them by shifting. It flags a missing input signal via a timeout and hands each averaged result downstream over a valid/ready handshake. The block sits between the capture unit and the frequency-computation/display logic, in single-shot or continuous mode.

---
 rtl/capture_sequencer.sv | 157 +++++++++++++++
 tb/tb_capture_sequencer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_sequencer.sv
// Input-capture controller: arms the capture unit, averages 2^k samples by
// shifting, flags a missing input by timeout and presents results over valid/ready.
module capture_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 150000000,
  parameter int unsigned MAX_LOG2       = 4,
  parameter int unsigned TW             = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          continuous,
  input  logic [2:0]    avg_log2,
  output logic          cap_clear,
  output logic          cap_en,
  input  logic          cap_done,
  input  logic [TW-1:0] cap_high,
  input  logic [TW-1:0] cap_low,
  input  logic [TW-1:0] cap_period,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [TW-1:0] avg_period,
  output logic [TW-1:0] avg_high,
  output logic [TW-1:0] avg_low,
  output logic          no_signal,
  output logic          busy
);

  localparam int unsigned AW  = TW + MAX_LOG2;
  localparam int unsigned CW  = MAX_LOG2 + 1;
  localparam int unsigned KW  = (MAX_LOG2 < 1) ? 1 : $clog2(MAX_LOG2 + 1);
  localparam int unsigned TOW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_WAIT,
    S_AVG,
    S_DONE
  } state_t;

  state_t         state, state_nx;
  logic           done_q;
  logic [KW-1:0]  k_q;
  logic [KW-1:0]  k_in;
  logic           cont_q;
  logic [AW-1:0]  acc_p, acc_h, acc_l;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_inc;
  logic [CW-1:0]  target;
  logic [TOW-1:0] tcnt;
  logic           sample_hit;
  logic           last_hit;
  logic           timeout_hit;

  always_comb begin
    k_in = KW'(avg_log2);
    if (32'(avg_log2) > MAX_LOG2) k_in = KW'(MAX_LOG2);
  end

  assign cnt_inc     = cnt + CW'(1);
  assign target      = CW'(1) << k_q;
  assign sample_hit  = (state == S_WAIT) && cap_done && !done_q;
  assign last_hit    = sample_hit && (cnt_inc == target);
  // A sample in the same cycle as the timeout threshold takes precedence.
  assign timeout_hit = (state == S_WAIT) && !sample_hit && (tcnt == TO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_CLEAR;
      S_CLEAR: state_nx = S_WAIT;
      S_WAIT: begin
        if (last_hit)         state_nx = S_AVG;
        else if (timeout_hit) state_nx = S_DONE;
      end
      S_AVG:   state_nx = S_DONE;
      S_DONE:  if (res_ready) state_nx = cont_q ? S_CLEAR : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) state_nx = S_IDLE;
  end

  assign cap_clear = (state == S_CLEAR);
  assign cap_en    = (state == S_WAIT);
  assign res_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q     <= 1'b0;
      k_q        <= '0;
      cont_q     <= 1'b0;
      acc_p      <= '0;
      acc_h      <= '0;
      acc_l      <= '0;
      cnt        <= '0;
      tcnt       <= '0;
      avg_period <= '0;
      avg_high   <= '0;
      avg_low    <= '0;
      no_signal  <= 1'b0;
    end else begin
      done_q <= cap_done;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            k_q    <= k_in;
            cont_q <= continuous;
          end
        end
        S_CLEAR: begin
          acc_p <= '0;
          acc_h <= '0;
          acc_l <= '0;
          cnt   <= '0;
          tcnt  <= '0;
        end
        S_WAIT: begin
          if (!abort) begin
            if (sample_hit) begin
              acc_p <= acc_p + AW'(cap_period);
              acc_h <= acc_h + AW'(cap_high);
              acc_l <= acc_l + AW'(cap_low);
              cnt   <= cnt_inc;
              tcnt  <= '0;
            end else begin
              tcnt <= tcnt + TOW'(1);
            end
            if (timeout_hit) begin
              no_signal  <= 1'b1;
              avg_period <= '0;
              avg_high   <= '0;
              avg_low    <= '0;
            end
          end
        end
        S_AVG: begin
          if (!abort) begin
            avg_period <= TW'(acc_p >> k_q);
            avg_high   <= TW'(acc_h >> k_q);
            avg_low    <= TW'(acc_l >> k_q);
            no_signal  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: table of averaging vectors plus
// hand-written sequences for reset, held done, back-pressure, timeout and abort.
module tb_capture_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, abort, continuous;
  logic [2:0]  avg_log2;
  logic        cap_clear, cap_en, cap_done;
  logic [31:0] cap_high, cap_low, cap_period;
  logic        res_valid, res_ready;
  logic [31:0] avg_period, avg_high, avg_low;
  logic        no_signal, busy;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  capture_sequencer #(
    .TIMEOUT_CYCLES(1000),
    .MAX_LOG2(4),
    .TW(32)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .continuous(continuous), .avg_log2(avg_log2),
    .cap_clear(cap_clear), .cap_en(cap_en), .cap_done(cap_done),
    .cap_high(cap_high), .cap_low(cap_low), .cap_period(cap_period),
    .res_valid(res_valid), .res_ready(res_ready),
    .avg_period(avg_period), .avg_high(avg_high), .avg_low(avg_low),
    .no_signal(no_signal), .busy(busy)
  );

  typedef struct {
    logic [2:0]  k;
    int unsigned n;
    logic [31:0] p[4];
    logic [31:0] h[4];
    logic [31:0] l[4];
    logic [31:0] ep, eh, el;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input logic [2:0] k, input logic cont);
    avg_log2 = k;
    continuous = cont;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("clear_pulse", {31'b0, cap_clear}, 1);
    chk("busy_clear", {31'b0, busy}, 1);
    tick();
    chk("clear_end", {31'b0, cap_clear}, 0);
    chk("en_wait", {31'b0, cap_en}, 1);
  endtask

  task automatic pulse_sample(input logic [31:0] p, input logic [31:0] h,
                              input logic [31:0] l, input logic last);
    cap_period = p;
    cap_high = h;
    cap_low = l;
    cap_done = 1'b1;
    tick();
    if (last) chk("latency_1", {31'b0, res_valid}, 0);
    cap_done = 1'b0;
    tick();
    if (last) chk("latency_2", {31'b0, res_valid}, 1);
  endtask

  task automatic accept(input logic exp_busy);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("accept_valid", {31'b0, res_valid}, 0);
    chk("accept_busy", {31'b0, busy}, {31'b0, exp_busy});
  endtask

  task automatic chk_result(input string tag, input logic [31:0] ep,
                            input logic [31:0] eh, input logic [31:0] el,
                            input logic ens);
    chk({tag, "_period"}, avg_period, ep);
    chk({tag, "_high"}, avg_high, eh);
    chk({tag, "_low"}, avg_low, el);
    chk({tag, "_no_signal"}, {31'b0, no_signal}, {31'b0, ens});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned cycles;
    logic        stable;

    vt[0] = '{k: 3'd0, n: 1,
              p: '{32'd2500000, 32'd0, 32'd0, 32'd0},
              h: '{32'd1250000, 32'd0, 32'd0, 32'd0},
              l: '{32'd1250000, 32'd0, 32'd0, 32'd0},
              ep: 32'd2500000, eh: 32'd1250000, el: 32'd1250000};
    vt[1] = '{k: 3'd2, n: 4,
              p: '{32'd1000000, 32'd1000002, 32'd999998, 32'd1000004},
              h: '{32'd500000, 32'd500001, 32'd499999, 32'd500003},
              l: '{32'd500000, 32'd500001, 32'd499999, 32'd500001},
              ep: 32'd1000001, eh: 32'd500000, el: 32'd500000};
    vt[2] = '{k: 3'd1, n: 2,
              p: '{32'd7, 32'd8, 32'd0, 32'd0},
              h: '{32'd3, 32'd4, 32'd0, 32'd0},
              l: '{32'd4, 32'd4, 32'd0, 32'd0},
              ep: 32'd7, eh: 32'd3, el: 32'd4};
    vt[3] = '{k: 3'd1, n: 2,
              p: '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0},
              h: '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'd0, 32'd0},
              l: '{32'd0, 32'd1, 32'd0, 32'd0},
              ep: 32'hFFFFFFFF, eh: 32'hFFFFFFFE, el: 32'd0};
    vt[4] = '{k: 3'd2, n: 4,
              p: '{32'd10, 32'd10, 32'd10, 32'd13},
              h: '{32'd1, 32'd2, 32'd3, 32'd4},
              l: '{32'd9, 32'd8, 32'd7, 32'd9},
              ep: 32'd10, eh: 32'd2, el: 32'd8};

    rst = 1'b0; start = 1'b0; abort = 1'b0; continuous = 1'b0;
    avg_log2 = '0; cap_done = 1'b0; res_ready = 1'b0;
    cap_period = '0; cap_high = '0; cap_low = '0;
    repeat (3) tick();
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_valid", {31'b0, res_valid}, 0);
    chk("rst_clear", {31'b0, cap_clear}, 0);
    chk("rst_en", {31'b0, cap_en}, 0);
    chk_result("rst", 0, 0, 0, 1'b0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      arm(vt[i].k, 1'b0);
      for (int j = 0; j < int'(vt[i].n); j++)
        pulse_sample(vt[i].p[j], vt[i].h[j], vt[i].l[j], j == int'(vt[i].n) - 1);
      chk_result($sformatf("vec%0d", i), vt[i].ep, vt[i].eh, vt[i].el, 1'b0);
      accept(1'b0);
    end

    // Reset mid-WAIT with three samples accumulated
    arm(3'd2, 1'b0);
    repeat (3) pulse_sample(32'd5, 32'd5, 32'd5, 1'b0);
    rst = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, busy}, 0);
    chk("midrst_en", {31'b0, cap_en}, 0);
    chk("midrst_valid", {31'b0, res_valid}, 0);
    chk_result("midrst", 0, 0, 0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    arm(3'd2, 1'b0);
    pulse_sample(32'd20, 32'd8, 32'd12, 1'b0);
    pulse_sample(32'd24, 32'd8, 32'd16, 1'b0);
    pulse_sample(32'd20, 32'd8, 32'd12, 1'b0);
    pulse_sample(32'd24, 32'd8, 32'd16, 1'b1);
    chk_result("after_rst", 32'd22, 32'd8, 32'd14, 1'b0);
    accept(1'b0);

    // cap_done held high for 10 cycles counts once
    arm(3'd2, 1'b0);
    cap_period = 32'd1000000; cap_high = 32'd500; cap_low = 32'd500;
    cap_done = 1'b1;
    repeat (10) tick();
    cap_done = 1'b0;
    tick();
    chk("held_once", {31'b0, res_valid}, 0);
    pulse_sample(32'd1000002, 32'd500, 32'd500, 1'b0);
    pulse_sample(32'd999998, 32'd500, 32'd500, 1'b0);
    pulse_sample(32'd1000004, 32'd500, 32'd500, 1'b1);
    chk_result("held", 32'd1000001, 32'd500, 32'd500, 1'b0);
    accept(1'b0);

    // Continuous mode with back-pressure and a done level high across re-arm
    arm(3'd1, 1'b1);
    pulse_sample(32'd100, 32'd40, 32'd60, 1'b0);
    pulse_sample(32'd102, 32'd42, 32'd60, 1'b1);
    stable = 1'b1;
    repeat (50) begin
      tick();
      if (res_valid !== 1'b1 || avg_period !== 32'd101 || avg_high !== 32'd41 ||
          avg_low !== 32'd60)
        stable = 1'b0;
    end
    chk("hold_stable", {31'b0, stable}, 1);
    cap_period = 32'd999; cap_high = 32'd999; cap_low = 32'd999;
    cap_done = 1'b1;
    repeat (2) tick();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("cont_valid_drop", {31'b0, res_valid}, 0);
    chk("cont_clear", {31'b0, cap_clear}, 1);
    tick();
    chk("cont_clear_end", {31'b0, cap_clear}, 0);
    chk("cont_en", {31'b0, cap_en}, 1);
    tick();
    cap_done = 1'b0;
    tick();
    pulse_sample(32'd200, 32'd50, 32'd150, 1'b0);
    chk("rearm_level", {31'b0, res_valid}, 0);
    pulse_sample(32'd204, 32'd54, 32'd150, 1'b1);
    chk_result("cont2", 32'd202, 32'd52, 32'd150, 1'b0);
    accept(1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("cont_abort_busy", {31'b0, busy}, 0);

    // Timeout with no done edge
    arm(3'd0, 1'b0);
    cycles = 0;
    while (res_valid !== 1'b1 && cycles < 1100) begin
      tick();
      cycles++;
    end
    chk("timeout_cycles", cycles, 1000);
    chk_result("timeout", 0, 0, 0, 1'b1);
    accept(1'b0);

    // Abort coincident with the final sample edge
    arm(3'd1, 1'b0);
    pulse_sample(32'd10, 32'd5, 32'd5, 1'b0);
    cap_period = 32'd12; cap_high = 32'd6; cap_low = 32'd6;
    cap_done = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    cap_done = 1'b0;
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_valid", {31'b0, res_valid}, 0);
    chk("abort_en", {31'b0, cap_en}, 0);
    tick();
    chk("abort_no_result", {31'b0, res_valid}, 0);
    chk_result("abort_keep", 0, 0, 0, 1'b1);

    // avg_log2=7 clamps to 16 samples
    arm(3'd7, 1'b0);
    for (int i = 0; i < 16; i++) begin
      pulse_sample(32'(100 + 2 * i), (i == 0) ? 32'd65 : 32'd50, 32'(i), i == 15);
      if (i == 14) chk("clamp_not_early", {31'b0, res_valid}, 0);
    end
    chk_result("clamp", 32'd115, 32'd50, 32'd7, 1'b0);
    accept(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule
